ifq_multi: RTL and testbench

//  Parametrised instruction fetch queue between i_cache and the dispatcher.

---
 rtl/riscv_fetch_pkg.sv | 21 ++
 rtl/ifq_word_ring.sv | 79 +++++++
 rtl/ifq_multi.sv | 141 ++++++++++++++
 tb/tb_ifq_multi.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-path types and address helpers used by the i_cache, fetch queue and
// dispatcher.
package riscv_fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  typedef logic [XLEN-1:0]    addr_t;
  typedef logic [INSTR_W-1:0] word_t;

  // Byte address of the start of the cache line holding addr.
  function automatic addr_t line_align(addr_t addr, int unsigned line_words);
    return addr & ~addr_t'(4 * line_words - 1);
  endfunction

  // Word index of addr within its cache line.
  function automatic addr_t word_offset(addr_t addr, int unsigned line_words);
    return (addr & addr_t'(4 * line_words - 1)) >> 2;
  endfunction

endpackage

// File: rtl/ifq_word_ring.sv
// Word-granular circular buffer: line-wide push from a start offset, multi-slot peek
// at the head, and a variable-size pop.
module ifq_word_ring
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned LINE_WORDS  = 4,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned OW          = $clog2(LINE_WORDS),
  parameter int unsigned NW          = $clog2(ISSUE_WIDTH + 1),
  parameter int unsigned PW          = $clog2(DEPTH * LINE_WORDS) + 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic                             push_i,
  input  logic [LINE_WORDS*INSTR_W-1:0]    push_data_i,
  input  logic [OW-1:0]                    push_start_i,
  input  logic [NW-1:0]                    pop_num_i,
  output logic [ISSUE_WIDTH*INSTR_W-1:0]   peek_data_o,
  output logic [PW-1:0]                    count_o,
  output logic                             full_o,
  output logic                             empty_o
);

  localparam int unsigned RW = DEPTH * LINE_WORDS;
  localparam int unsigned AW = PW - 1;

  word_t         mem [RW];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  // Pointers carry one extra bit so a completely full ring is distinct from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q + PW'(pop_num_i);
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + PW'(LINE_WORDS) - PW'(push_start_i);
    end
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Words below push_start are skipped; the rest pack densely from wr_ptr.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      for (int j = 0; j < LINE_WORDS; j++) begin
        if (j >= int'(push_start_i)) begin
          mem[AW'(int'(wr_ptr_q[AW-1:0]) + j - int'(push_start_i))] <=
              push_data_i[INSTR_W*j +: INSTR_W];
        end
      end
    end
  end

  always_comb begin
    peek_data_o = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      peek_data_o[INSTR_W*k +: INSTR_W] = mem[AW'(int'(rd_ptr_q[AW-1:0]) + k)];
    end
  end

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = count_o > PW'(RW - LINE_WORDS);
  assign empty_o = (count_o == '0);

endmodule

// File: rtl/ifq_multi.sv
// Instruction fetch queue: requests cache lines, buffers them as words and presents up
// to ISSUE_WIDTH in-order instructions per cycle; handles branch redirect and abort.
module ifq_multi
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned LINE_WORDS  = 4,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter logic [31:0] RESET_PC    = 32'h0040_0000
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [LINE_WORDS*32-1:0]           i_cache_dout,
  input  logic                               i_cache_dout_valid,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]   i_rd_num,
  input  logic [31:0]                        i_jmp_branch_address,
  input  logic                               i_jmp_branch_valid,
  output logic [31:0]                        o_pc_in,
  output logic                               o_cache_rd_en,
  output logic                               o_abort,
  output logic [ISSUE_WIDTH*32-1:0]          o_instr,
  output logic [ISSUE_WIDTH*32-1:0]          o_pc_out,
  output logic [ISSUE_WIDTH-1:0]             o_valid,
  output logic                               o_empty,
  output logic                               o_full
);

  localparam int unsigned RW = DEPTH * LINE_WORDS;
  localparam int unsigned PW = $clog2(RW) + 1;
  localparam int unsigned OW = $clog2(LINE_WORDS);
  localparam int unsigned NW = $clog2(ISSUE_WIDTH + 1);

  addr_t          pc_in_q, pc_in_d;
  addr_t          head_pc_q, head_pc_d;
  logic           rd_en_q, rd_en_d;
  logic           abort_q, abort_d;
  logic           outstanding_q, outstanding_d;
  logic [OW-1:0]  skip_q, skip_d;

  logic [PW-1:0]  count;
  logic           ring_full;
  logic           ring_empty;
  logic [NW-1:0]  avail;
  logic [NW-1:0]  consumed;
  logic [NW-1:0]  pop_num;
  logic           fill;
  logic           req;

  // Pop is clamped to the number of slots actually presented.
  always_comb begin
    if (count >= PW'(ISSUE_WIDTH)) begin
      avail = NW'(ISSUE_WIDTH);
    end else begin
      avail = NW'(count);
    end
    consumed = (i_rd_num > avail) ? avail : i_rd_num;
  end

  // A redirect discards any same-cycle fill or pop.
  assign fill    = i_cache_dout_valid & outstanding_q & ~i_jmp_branch_valid;
  assign req     = ~outstanding_q & ~ring_full & ~i_jmp_branch_valid;
  assign pop_num = i_jmp_branch_valid ? '0 : consumed;

  always_comb begin
    pc_in_d       = pc_in_q;
    head_pc_d     = head_pc_q + (addr_t'(consumed) << 2);
    skip_d        = skip_q;
    outstanding_d = outstanding_q;
    rd_en_d       = 1'b0;
    abort_d       = 1'b0;
    if (i_jmp_branch_valid) begin
      abort_d       = outstanding_q;
      outstanding_d = 1'b0;
      pc_in_d       = line_align(i_jmp_branch_address, LINE_WORDS);
      skip_d        = OW'(word_offset(i_jmp_branch_address, LINE_WORDS));
      head_pc_d     = i_jmp_branch_address;
    end else begin
      if (fill) begin
        outstanding_d = 1'b0;
        skip_d        = '0;
        pc_in_d       = pc_in_q + addr_t'(4 * LINE_WORDS);
      end
      if (req) begin
        outstanding_d = 1'b1;
        rd_en_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_in_q       <= RESET_PC;
      head_pc_q     <= RESET_PC;
      rd_en_q       <= 1'b0;
      abort_q       <= 1'b0;
      outstanding_q <= 1'b0;
      skip_q        <= '0;
    end else begin
      pc_in_q       <= pc_in_d;
      head_pc_q     <= head_pc_d;
      rd_en_q       <= rd_en_d;
      abort_q       <= abort_d;
      outstanding_q <= outstanding_d;
      skip_q        <= skip_d;
    end
  end

  ifq_word_ring #(
    .LINE_WORDS  (LINE_WORDS),
    .DEPTH       (DEPTH),
    .ISSUE_WIDTH (ISSUE_WIDTH)
  ) u_ring (
    .clk_i        (i_clk),
    .rst_i        (i_rst),
    .flush_i      (i_jmp_branch_valid),
    .push_i       (fill),
    .push_data_i  (i_cache_dout),
    .push_start_i (skip_q),
    .pop_num_i    (pop_num),
    .peek_data_o  (o_instr),
    .count_o      (count),
    .full_o       (ring_full),
    .empty_o      (ring_empty)
  );

  always_comb begin
    o_valid  = '0;
    o_pc_out = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      o_valid[k]          = count > PW'(k);
      o_pc_out[32*k +: 32] = head_pc_q + addr_t'(4 * k + 4);
    end
  end

  assign o_pc_in       = pc_in_q;
  assign o_cache_rd_en = rd_en_q;
  assign o_abort       = abort_q;
  assign o_empty       = ring_empty;
  assign o_full        = ring_full;

endmodule

// File: tb/tb_ifq_multi.sv
// Bench for ifq_multi: cache model plus word scoreboard checked every cycle, a vector
// table for the drain sequence, and directed redirect/odd-count/wrap sequences.
module tb_ifq_multi;

  localparam int LW = 4;
  localparam int DEPTH = 4;
  localparam int IW = 2;
  localparam int RW = DEPTH * LW;
  localparam logic [31:0] RPC = 32'h0040_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [LW*32-1:0] dout = '0;
  logic            dout_valid = 1'b0;
  logic [1:0]      rd_num = '0;
  logic [31:0]     jmp_addr = '0;
  logic            jmp_valid = 1'b0;
  logic [31:0]     pc_in;
  logic            rd_en;
  logic            abort;
  logic [IW*32-1:0] instr;
  logic [IW*32-1:0] pc_out;
  logic [IW-1:0]   valid;
  logic            empty;
  logic            full;

  always #5 clk = ~clk;

  ifq_multi #(
    .LINE_WORDS  (LW),
    .DEPTH       (DEPTH),
    .ISSUE_WIDTH (IW),
    .RESET_PC    (RPC)
  ) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_cache_dout         (dout),
    .i_cache_dout_valid   (dout_valid),
    .i_rd_num             (rd_num),
    .i_jmp_branch_address (jmp_addr),
    .i_jmp_branch_valid   (jmp_valid),
    .o_pc_in              (pc_in),
    .o_cache_rd_en        (rd_en),
    .o_abort              (abort),
    .o_instr              (instr),
    .o_pc_out             (pc_out),
    .o_valid              (valid),
    .o_empty              (empty),
    .o_full               (full)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc_out;
  } ent_t;

  typedef struct {
    logic [1:0]  rd;
    logic [31:0] pc0;
    logic [1:0]  valid;
    logic        full;
    logic        empty;
  } vec_t;

  ent_t q[$];
  int checks = 0;
  int passes = 0;

  // Cache and fetch-side model state
  bit          cache_en = 1'b0;
  int          cache_lat = 0;
  bit          req_pend = 1'b0;
  int          req_wait = 0;
  logic [31:0] req_addr = '0;
  bit          fill_drv = 1'b0;
  logic [31:0] fill_addr = '0;
  int          fill_skip = 0;
  logic [31:0] exp_pc = RPC;
  int          exp_skip = 0;
  logic        exp_abort = 1'b0;
  int          nreq = 0;
  int          nfill = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic check_slots();
    int n;
    logic [IW-1:0] ev;
    n = (q.size() < IW) ? q.size() : IW;
    ev = '0;
    for (int k = 0; k < n; k++) ev[k] = 1'b1;
    chk("valid", 32'(valid), 32'(ev));
    for (int k = 0; k < n; k++) begin
      chk("instr", instr[32*k +: 32], q[k].instr);
      chk("pc_out", pc_out[32*k +: 32], q[k].pc_out);
    end
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'((RW - q.size()) < LW));
  endtask

  // One clock: apply model effects of the edge, check outputs, then run the cache model.
  task automatic tick();
    int n;
    logic [31:0] a;
    @(posedge clk);
    #1;
    if (jmp_valid) begin
      exp_abort = req_pend || fill_drv;
      req_pend  = 1'b0;
      q.delete();
      exp_pc    = jmp_addr & ~32'hF;
      exp_skip  = int'(jmp_addr[3:2]);
    end else begin
      exp_abort = 1'b0;
      n = (int'(rd_num) < q.size()) ? int'(rd_num) : q.size();
      if (n > IW) n = IW;
      for (int i = 0; i < n; i++) q.delete(0);
      if (fill_drv) begin
        for (int j = fill_skip; j < LW; j++) begin
          a = fill_addr + 32'(4 * j);
          q.push_back('{instr_of(a), a + 32'd4});
        end
        exp_pc   = fill_addr + 32'd16;
        exp_skip = 0;
        nfill++;
      end
    end
    jmp_valid  = 1'b0;
    dout_valid = 1'b0;
    fill_drv   = 1'b0;
    check_slots();
    chk("abort", 32'(abort), 32'(exp_abort));
    if (rd_en) begin
      chk("one_outstanding", 32'(req_pend), 32'd0);
      chk("pc_in", pc_in, exp_pc);
      req_pend = 1'b1;
      req_addr = pc_in;
      req_wait = cache_lat;
      nreq++;
    end
    if (req_pend && cache_en) begin
      if (req_wait == 0) begin
        for (int j = 0; j < LW; j++) dout[32*j +: 32] = instr_of(req_addr + 32'(4 * j));
        dout_valid = 1'b1;
        fill_drv   = 1'b1;
        fill_addr  = req_addr;
        fill_skip  = exp_skip;
        req_pend   = 1'b0;
      end else begin
        req_wait--;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    logic [31:0] prev;
    int k0;

    // Drain of a full queue with the cache stalled; start: 16 words from RESET_PC.
    vecs[0] = '{2'd2, 32'h0040_000C, 2'b11, 1'b1, 1'b0};
    vecs[1] = '{2'd2, 32'h0040_0014, 2'b11, 1'b0, 1'b0};
    vecs[2] = '{2'd1, 32'h0040_0018, 2'b11, 1'b0, 1'b0};
    vecs[3] = '{2'd3, 32'h0040_0020, 2'b11, 1'b0, 1'b0};
    vecs[4] = '{2'd0, 32'h0040_0020, 2'b11, 1'b0, 1'b0};
    vecs[5] = '{2'd2, 32'h0040_0028, 2'b11, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc_in", pc_in, RPC);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    rst = 1'b0;

    // Fill until full with no consumption.
    cache_en = 1'b1;
    repeat (20) tick();
    chk("fill_req_count", 32'(nreq), 32'd4);
    chk("full_after_4", 32'(full), 32'd1);
    chk("first_pc_out", pc_out[31:0], 32'h0040_0004);
    chk("first_instr", instr[31:0], instr_of(RPC));

    cache_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rd_num = vecs[i].rd;
      tick();
      chk("tbl_pc0", pc_out[31:0], vecs[i].pc0);
      chk("tbl_instr0", instr[31:0], instr_of(vecs[i].pc0 - 32'd4));
      chk("tbl_valid", 32'(valid), 32'(vecs[i].valid));
      chk("tbl_full", 32'(full), 32'(vecs[i].full));
      chk("tbl_empty", 32'(empty), 32'(vecs[i].empty));
    end
    rd_num = 2'd0;

    // Redirect while a request is outstanding, then a late response.
    jmp_addr  = 32'h0040_0108;
    jmp_valid = 1'b1;
    tick();
    chk("redir_abort", 32'(abort), 32'd1);
    chk("redir_empty", 32'(empty), 32'd1);
    dout       = {LW{32'hDEAD_BEEF}};
    dout_valid = 1'b1;
    tick();
    chk("late_abort_clear", 32'(abort), 32'd0);
    chk("late_ignored", 32'(empty), 32'd1);
    cache_en = 1'b1;
    for (int i = 0; i < 10 && !valid[0]; i++) tick();
    chk("redir_instr", instr[31:0], instr_of(32'h0040_0108));
    chk("redir_pc_out", pc_out[31:0], 32'h0040_010C);

    // Steady dual issue.
    repeat (8) tick();
    rd_num = 2'd2;
    prev = q[0].pc_out;
    repeat (20) begin
      tick();
      prev = prev + 32'd8;
      chk("steady_valid", 32'(valid), 32'b11);
      chk("steady_step", pc_out[31:0], prev);
    end

    // Odd count: single line with one skipped word leaves three.
    rd_num    = 2'd0;
    cache_en  = 1'b0;
    jmp_addr  = 32'h0040_0204;
    jmp_valid = 1'b1;
    tick();
    cache_en = 1'b1;
    k0 = nfill;
    for (int i = 0; i < 10 && nfill == k0; i++) tick();
    cache_en = 1'b0;
    chk("odd_three", 32'(valid), 32'b11);
    chk("odd_head", pc_out[31:0], 32'h0040_0208);
    rd_num = 2'd2;
    tick();
    chk("odd_one_left", 32'(valid), 32'b01);
    chk("odd_one_pc", pc_out[31:0], 32'h0040_0210);
    tick();
    chk("odd_clamped_empty", 32'(empty), 32'd1);
    chk("odd_clamped_valid", 32'(valid), 32'd0);
    tick();
    chk("empty_pop_ignored", 32'(empty), 32'd1);
    rd_num   = 2'd0;
    cache_en = 1'b1;
    for (int i = 0; i < 10 && !valid[0]; i++) tick();
    chk("empty_head_pc", pc_out[31:0], 32'h0040_0214);

    // Many fills and random pops so both pointers wrap several times.
    cache_lat = 1;
    k0 = nfill;
    repeat (80) begin
      rd_num = 2'($urandom_range(0, 2));
      tick();
    end
    rd_num = 2'd0;
    chk("wrap_fills", 32'(nfill - k0 >= 10), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
